mmio_responder: RTL

Memory-mapped I/O responder on the hart's data-memory port. It answers load/store requests in a fixed address window and drives the board LEDs and six 7-segment displays from software-written registers. It also returns the synchronized slide switches and push-buttons to software, with sticky press-event capture. It sits beside data RAM in the board top level, replacing direct debug wiring of register state to the LEDs.

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/mmio_responder_seg7_decoder.sv | 34 +++
 rtl/mmio_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, FSM states, HEX register format.
// The HEX register format depends on the MMIO_HEX_DECODE_EN build macro.
package mmio_pkg;

  localparam logic [5:0] OFF_LEDR     = 6'h00;
  localparam logic [5:0] OFF_SW       = 6'h04;
  localparam logic [5:0] OFF_KEY      = 6'h08;
  localparam logic [5:0] OFF_KEY_EDGE = 6'h0C;
  localparam logic [5:0] OFF_HEX0     = 6'h10;
  localparam logic [5:0] OFF_HEX5     = 6'h24;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

`ifdef MMIO_HEX_DECODE_EN
  // [3:0] digit, [4] blank
  localparam int unsigned     HEX_W   = 5;
  localparam logic [HEX_W-1:0] HEX_RST = 5'h10;
`else
  localparam int unsigned     HEX_W   = 7;
  localparam logic [HEX_W-1:0] HEX_RST = SEG_BLANK;
`endif

  typedef enum logic {IDLE, RESP} mmio_state_t;

endpackage

// File: rtl/mmio_responder_seg7_decoder.sv
// Hex digit to active-low 7-segment pattern (bit order gfedcba); blank forces all segments off.
module seg7_decoder
  import mmio_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        default: seg = 7'h0E;
      endcase
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped LED/HEX/switch/button responder on the hart data port (64-byte window).
// Build macro MMIO_HEX_DECODE_EN selects hardware hex decode for HEX0..HEX5.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  mmio_state_t      state, state_next;
  logic [9:0]       sw_sync  [SYNC_STAGES];
  logic [3:0]       key_sync [SYNC_STAGES];
  logic [3:0]       pressed, pressed_q, key_edge_q, key_clr;
  logic [9:0]       ledr_q;
  logic [HEX_W-1:0] hex_q [6];
  logic [6:0]       hex_seg [6];
  logic [31:0]      rsp_rdata_q, rd_data;
  logic             rsp_error_q, rd_err;
  logic             in_window, accept, wr_en, is_hex;
  logic [5:0]       off;
  logic [2:0]       hex_sel;
  logic             unused_bits;

  assign unused_bits = ^{req_addr[1:0], req_wdata[31:10]};

  assign in_window = (req_addr[31:6] == BASE_ADDR[31:6]);
  assign off       = {req_addr[5:2], 2'b00};
  assign is_hex    = (off >= OFF_HEX0) && (off <= OFF_HEX5);
  assign hex_sel   = 3'(req_addr[5:2] - OFF_HEX0[5:2]);
  assign pressed   = ~key_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= '0;
        key_sync[i] <= '1;
      end
    end else begin
      sw_sync[0]  <= SW;
      key_sync[0] <= KEY;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        key_sync[i] <= key_sync[i-1];
      end
    end
  end

  // Read mux doubles as the error decode: RO stores and unmapped offsets fail.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (off == OFF_LEDR) begin
      rd_data = {22'b0, ledr_q};
    end else if (off == OFF_SW) begin
      rd_data = {22'b0, sw_sync[SYNC_STAGES-1]};
      rd_err  = req_write;
    end else if (off == OFF_KEY) begin
      rd_data = {28'b0, pressed};
      rd_err  = req_write;
    end else if (off == OFF_KEY_EDGE) begin
      rd_data = {28'b0, key_edge_q};
    end else if (is_hex) begin
      rd_data = 32'(hex_q[hex_sel]);
    end else begin
      rd_err = 1'b1;
    end
    if (req_write || rd_err) rd_data = '0;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !(req_valid && !in_window);
        if (req_valid && in_window) begin
          accept     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign wr_en   = accept && req_write && !rd_err;
  assign key_clr = (wr_en && off == OFF_KEY_EDGE) ? req_wdata[3:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ledr_q      <= '0;
      pressed_q   <= '0;
      key_edge_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) hex_q[i] <= HEX_RST;
    end else begin
      pressed_q  <= pressed;
      // A new edge overrides a same-cycle clear.
      key_edge_q <= (key_edge_q & ~key_clr) | (pressed & ~pressed_q);
      if (accept) begin
        rsp_rdata_q <= rd_data;
        rsp_error_q <= rd_err;
      end
      if (wr_en && off == OFF_LEDR) ledr_q <= req_wdata[9:0];
      if (wr_en && is_hex)          hex_q[hex_sel] <= req_wdata[HEX_W-1:0];
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_hex
`ifdef MMIO_HEX_DECODE_EN
    seg7_decoder u_dec (
      .digit (hex_q[g][3:0]),
      .blank (hex_q[g][4]),
      .seg   (hex_seg[g])
    );
`else
    assign hex_seg[g] = hex_q[g];
`endif
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign LEDR      = ledr_q;
  assign HEX0      = hex_seg[0];
  assign HEX1      = hex_seg[1];
  assign HEX2      = hex_seg[2];
  assign HEX3      = hex_seg[3];
  assign HEX4      = hex_seg[4];
  assign HEX5      = hex_seg[5];

endmodule
